// File: rtl/conv1d_multi_filter.sv
// conv1d_multi_filter: int8 1-D convolution CFU that computes several output
// channels for one window position per start command.
//
// An int8 input ring buffer and a bank of int8 kernels are written by the CPU.
// A LANES-wide MAC reads the window in ceil(W/LANES) issue cycles through a
// two-stage pipeline: lane products are registered, then their sum is added
// to the accumulator. Each filter's result goes into a small result buffer
// that the CPU reads back through cmd/inp0/inp1/ret.
//
// Optional feature macro: CONV1D_MULTI_QUANT_EN
//   defined   : a QUANT state runs before STORE. It starts the external
//               quant module with acc+bias[f], waits for ret_valid and stores
//               quant's ret. The expected quant port list is clk, rst, en,
//               start, acc, output_multiplier, output_shift, activation_min,
//               activation_max, output_offset, ret, ret_valid.
//   undefined : result[f] = acc + bias[f] (raw 32-bit). The quant parameter
//               commands still write their registers.
//
// FSM states
//   state    | meaning
//   S_IDLE   | waiting for start (cmd 6)
//   S_RUN    | issuing LANES window elements per cycle into stage 1
//   S_DRAIN1 | last stage-1 products are being added to acc
//   S_DRAIN2 | acc is final
//   S_QUANT  | waiting for quant result (quant build only)
//   S_STORE  | write result[f], then start the next filter or finish
module conv1d_multi_filter #(
  parameter int KERNEL_LENGTH      = 8,
  parameter int MAX_INPUT_CHANNELS = 128,
  parameter int MAX_FILTERS        = 4,
  parameter int LANES              = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  cmd,
  input  logic [31:0] inp0,
  input  logic [31:0] inp1,
  output logic [31:0] ret,
  output logic        output_buffer_valid,
  output logic        busy
);

  localparam int FILT_STRIDE = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
  localparam int RING_SZ     = (KERNEL_LENGTH + 1) * MAX_INPUT_CHANNELS;
  localparam int FILT_SZ     = MAX_FILTERS * FILT_STRIDE;
  localparam int RAW         = $clog2(RING_SZ);
  localparam int FAW         = $clog2(FILT_SZ);
  localparam int FW          = (MAX_FILTERS > 1) ? $clog2(MAX_FILTERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2, S_QUANT, S_STORE
  } state_t;

  // Buffers are deliberately not reset; only their contents matter.
  logic [7:0] ring_mem [RING_SZ];
  logic [7:0] filt_mem [FILT_SZ];

  state_t             state_q;
  logic               busy_q, done_q, v1_q;
  logic [31:0]        ret_q;
  logic signed [31:0] acc_q;
  logic [FW-1:0]      f_q;
  logic [31:0]        j_q, base_q, win_len_q, ring_sz_q;
  logic signed [31:0] prod_q [LANES];

  logic [31:0]        input_offset_q, num_filters_q, input_depth_q, start_x_q;
  logic [31:0]        bias_q   [MAX_FILTERS];
  logic [31:0]        result_q [MAX_FILTERS];
  logic [31:0]        out_mult_q, out_shift_q, act_min_q, act_max_q, out_offset_q;

  logic [31:0]        wr_addr [4];
  logic [31:0]        eff_depth_d, ring_sz_d, win_len_d, win_start_d, base_d;
  logic [31:0]        f_base_d, f_next_d;
  logic [31:0]        lane_j    [LANES];
  logic [31:0]        lane_ridx [LANES];
  logic [31:0]        lane_fidx [LANES];
  logic [7:0]         lane_rb   [LANES];
  logic [7:0]         lane_fb   [LANES];
  logic signed [31:0] lane_x    [LANES];
  logic signed [31:0] prod_d    [LANES];
  logic signed [31:0] sum_d;
  logic [31:0]        store_val_d;

`ifdef CONV1D_MULTI_QUANT_EN
  logic               q_start_q;
  logic signed [31:0] q_acc_q;
  logic [31:0]        q_res_q;
  logic [31:0]        q_ret;
  logic               q_ret_valid;

  quant u_quant (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .start             (q_start_q),
    .acc               (q_acc_q),
    .output_multiplier (out_mult_q),
    .output_shift      (out_shift_q),
    .activation_min    (act_min_q),
    .activation_max    (act_max_q),
    .output_offset     (out_offset_q),
    .ret               (q_ret),
    .ret_valid         (q_ret_valid)
  );
  assign store_val_d = q_res_q;
`else
  logic unused_quant_cfg;
  assign unused_quant_cfg = ^{out_mult_q, out_shift_q, act_min_q, act_max_q, out_offset_q};
  assign store_val_d = acc_q + bias_q[f_q];
`endif

  // Byte addresses for the four bytes of a cmd 1/2 write
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_addr[k] = inp0 + 32'(k);
    end
  end

  // Window geometry for the next start; depth clamped to the buffer capacity
  always_comb begin
    eff_depth_d = (input_depth_q > 32'(MAX_INPUT_CHANNELS)) ? 32'(MAX_INPUT_CHANNELS)
                                                            : input_depth_q;
    ring_sz_d   = 32'(KERNEL_LENGTH + 1) * eff_depth_d;
    win_len_d   = 32'(KERNEL_LENGTH) * eff_depth_d;
    win_start_d = start_x_q * eff_depth_d;
    base_d      = (win_start_d >= ring_sz_d) ? win_start_d - ring_sz_d : win_start_d;
    f_base_d    = 32'(f_q) * 32'(FILT_STRIDE);
    f_next_d    = 32'(f_q) + 32'd1;
  end

  // Stage-1 lane products; lanes past the window end contribute zero
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_j[l]    = j_q + 32'(l);
      lane_ridx[l] = base_q + lane_j[l];
      if (lane_ridx[l] >= ring_sz_q) lane_ridx[l] = lane_ridx[l] - ring_sz_q;
      lane_fidx[l] = f_base_d + lane_j[l];
      lane_rb[l]   = ring_mem[lane_ridx[l][RAW-1:0]];
      lane_fb[l]   = filt_mem[lane_fidx[l][FAW-1:0]];
      lane_x[l]    = $signed({{24{lane_rb[l][7]}}, lane_rb[l]}) + $signed(input_offset_q);
      prod_d[l]    = (lane_j[l] < win_len_q)
                   ? $signed({{24{lane_fb[l][7]}}, lane_fb[l]}) * lane_x[l]
                   : 32'sd0;
    end
  end

  // Stage-2 adder tree over the registered products
  always_comb begin
    sum_d = 32'sd0;
    for (int l = 0; l < LANES; l++) begin
      sum_d = sum_d + prod_q[l];
    end
  end

  // Buffer writes, accepted in every FSM state
  always_ff @(posedge clk) begin
    if (en && cmd == 7'd1) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_addr[k] < 32'(RING_SZ)) ring_mem[wr_addr[k][RAW-1:0]] <= inp1[8*k +: 8];
      end
    end
    if (en && cmd == 7'd2) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_addr[k] < 32'(FILT_SZ)) filt_mem[wr_addr[k][FAW-1:0]] <= inp1[8*k +: 8];
      end
    end
  end

  // Command decode, MAC pipeline and sequencing FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b1;
      v1_q           <= 1'b0;
      ret_q          <= '0;
      acc_q          <= '0;
      f_q            <= '0;
      j_q            <= '0;
      base_q         <= '0;
      win_len_q      <= '0;
      ring_sz_q      <= '0;
      input_offset_q <= '0;
      num_filters_q  <= '0;
      input_depth_q  <= '0;
      start_x_q      <= '0;
      out_mult_q     <= '0;
      out_shift_q    <= '0;
      act_min_q      <= '0;
      act_max_q      <= '0;
      out_offset_q   <= '0;
      for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
      for (int i = 0; i < MAX_FILTERS; i++) begin
        bias_q[i]   <= '0;
        result_q[i] <= '0;
      end
`ifdef CONV1D_MULTI_QUANT_EN
      q_start_q <= 1'b0;
      q_acc_q   <= '0;
      q_res_q   <= '0;
`endif
    end else if (en) begin
      ret_q <= '0;
      case (cmd)
        7'd0:  ret_q <= 32'(FILT_STRIDE);
        7'd3:  input_offset_q <= inp1;
        7'd4:  num_filters_q <= inp1;
        7'd5:  input_depth_q <= inp1;
        7'd7:  if (inp0 < 32'(MAX_FILTERS)) ret_q <= result_q[inp0[FW-1:0]];
        7'd8:  start_x_q <= inp1;
        7'd9:  ret_q <= {31'd0, done_q};
        7'd10: if (inp0 < 32'(MAX_FILTERS)) bias_q[inp0[FW-1:0]] <= inp1;
        7'd11: out_mult_q <= inp1;
        7'd12: out_shift_q <= inp1;
        7'd13: act_min_q <= inp1;
        7'd14: act_max_q <= inp1;
        7'd15: out_offset_q <= inp1;
        default: ;
      endcase

      v1_q <= 1'b0;
      if (v1_q) acc_q <= acc_q + sum_d;
`ifdef CONV1D_MULTI_QUANT_EN
      q_start_q <= 1'b0;
`endif

      case (state_q)
        S_IDLE: begin
          if (cmd == 7'd6) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            acc_q     <= '0;
            f_q       <= '0;
            j_q       <= '0;
            base_q    <= base_d;
            win_len_q <= win_len_d;
            ring_sz_q <= ring_sz_d;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES; l++) prod_q[l] <= prod_d[l];
          v1_q <= 1'b1;
          if (j_q + 32'(LANES) >= win_len_q) state_q <= S_DRAIN1;
          else j_q <= j_q + 32'(LANES);
        end
        S_DRAIN1: state_q <= S_DRAIN2;
        S_DRAIN2: begin
`ifdef CONV1D_MULTI_QUANT_EN
          state_q   <= S_QUANT;
          q_start_q <= 1'b1;
          q_acc_q   <= acc_q + $signed(bias_q[f_q]);
`else
          state_q <= S_STORE;
`endif
        end
`ifdef CONV1D_MULTI_QUANT_EN
        S_QUANT: begin
          if (q_ret_valid) begin
            q_res_q <= q_ret;
            state_q <= S_STORE;
          end
        end
`endif
        S_STORE: begin
          result_q[f_q] <= store_val_d;
          if (f_next_d < num_filters_q && f_next_d < 32'(MAX_FILTERS)) begin
            f_q     <= f_q + 1'b1;
            acc_q   <= '0;
            j_q     <= '0;
            state_q <= S_RUN;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ret                 = ret_q;
  assign busy                = busy_q;
  assign output_buffer_valid = 1'b1;

endmodule

// File: tb/tb_conv1d_multi_filter.sv
// Directed bench for conv1d_multi_filter. Two instances (LANES=8 and
// LANES=16) receive the same command stream; expected results are queued
// when a start is issued and popped when the result buffer is read back.
module tb_conv1d_multi_filter;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [6:0]  cmd;
  logic [31:0] inp0, inp1;
  logic [31:0] ret8, ret16;
  logic        obv8, obv16, busy8, busy16;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  conv1d_multi_filter #(.LANES(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .ret(ret8), .output_buffer_valid(obv8), .busy(busy8)
  );

  conv1d_multi_filter #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .ret(ret16), .output_buffer_valid(obv16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One command per clock edge; ret is sampled 1 time unit after the edge.
  task automatic io(input int c, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] r8, output logic [31:0] r16);
    @(negedge clk);
    cmd  = 7'(c);
    inp0 = a;
    inp1 = d;
    @(posedge clk);
    #1;
    r8  = ret8;
    r16 = ret16;
    cmd = 7'd16;
  endtask

  task automatic wr(input int c, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r8, r16;
    io(c, a, d, r8, r16);
  endtask

  // Poll cmd 9 on consecutive edges k0..max(n)+1 after a start at edge T.
  // done must read 0 up to edge T+n and 1 from edge T+n+1.
  task automatic poll_done(input int k0, input int n8, input int n16, input string tag);
    logic [31:0] r8, r16;
    int kmax;
    kmax = ((n8 > n16) ? n8 : n16) + 1;
    for (int k = k0; k <= kmax; k++) begin
      io(9, 0, 0, r8, r16);
      chk({tag, "_done_l8"},  r8,  (k > n8)  ? 32'd1 : 32'd0);
      chk({tag, "_done_l16"}, r16, (k > n16) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic read_results(input int nf, input string tag);
    logic [31:0] r8, r16;
    int e;
    for (int i = 0; i < nf; i++) begin
      io(7, i, 0, r8, r16);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_res_l8"},  r8,  32'(e));
        chk({tag, "_res_l16"}, r16, 32'(e));
      end
    end
  endtask

  initial begin
    logic [31:0] r8, r16;
    rst  = 1'b1;
    en   = 1'b1;
    cmd  = 7'd16;
    inp0 = '0;
    inp1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ret",  ret8,  32'd0);
    chk("rst_busy", {31'd0, busy8 | busy16}, 32'd0);
    chk("rst_obv",  {30'd0, obv8, obv16}, 32'd3);
    io(9, 0, 0, r8, r16);
    chk("rst_done", r8, 32'd1);
    io(7, 0, 0, r8, r16);
    chk("rst_result", r16, 32'd0);
    io(0, 0, 0, r8, r16);
    chk("cmd0_size", r8, 32'd1024);

    // Basic: depth 1, ring 1..8, filter all 1 -> 36, done after 4 edges
    wr(5, 0, 1);
    wr(4, 0, 1);
    wr(3, 0, 0);
    wr(8, 0, 0);
    wr(1, 0, 32'h04030201);
    wr(1, 4, 32'h08070605);
    wr(2, 0, 32'h01010101);
    wr(2, 4, 32'h01010101);
    exp_q.push_back(36);
    wr(6, 0, 0);
    poll_done(1, 4, 4, "basic");
    read_results(1, "basic");

    // Reset in the middle of RUN, then rerun without reloading buffers
    wr(6, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy8 | busy16}, 32'd0);
    io(9, 0, 0, r8, r16);
    chk("midrst_done", r8, 32'd1);
    io(7, 0, 0, r8, r16);
    chk("midrst_result", r8, 32'd0);
    wr(5, 0, 1);
    wr(4, 0, 1);
    exp_q.push_back(36);
    wr(6, 0, 0);
    poll_done(1, 4, 4, "rerun");
    read_results(1, "rerun");

    // Wrap: R=9, ring[i]=i, start_x=5 -> 5+6+7+8+0+1+2+3 = 32
    wr(1, 0, 32'h03020100);
    wr(1, 4, 32'h07060504);
    wr(1, 8, 32'h00000008);
    wr(8, 0, 5);
    exp_q.push_back(32);
    wr(6, 0, 0);
    poll_done(1, 4, 4, "wrap");
    read_results(1, "wrap");

    // Two filters, offset 3: 8*2*4 = 64 and 8*(-1)*4 + 10 = -22
    wr(1, 0, 32'h01010101);
    wr(1, 4, 32'h01010101);
    wr(1, 8, 32'h01010101);
    wr(8, 0, 0);
    wr(4, 0, 2);
    wr(3, 0, 3);
    wr(2, 0, 32'h02020202);
    wr(2, 4, 32'h02020202);
    wr(2, 1024, 32'hFFFFFFFF);
    wr(2, 1028, 32'hFFFFFFFF);
    wr(10, 1, 10);
    exp_q.push_back(64);
    exp_q.push_back(-22);
    wr(6, 0, 0);
    poll_done(1, 8, 8, "multi");
    read_results(2, "multi");

    // Lane masking: depth 3, W=24, garbage in filter bytes 24..31 -> 24.
    // LANES=8 needs 3 issues (6 edges), LANES=16 needs 2 (5 edges).
    wr(5, 0, 3);
    wr(4, 0, 1);
    wr(3, 0, 0);
    for (int a = 0; a < 28; a += 4) wr(1, a, 32'h01010101);
    for (int a = 0; a < 24; a += 4) wr(2, a, 32'h01010101);
    wr(2, 24, 32'h7F7F7F7F);
    wr(2, 28, 32'h7F7F7F7F);
    exp_q.push_back(24);
    wr(6, 0, 0);
    poll_done(1, 6, 5, "mask");
    read_results(1, "mask");

    // Start while busy is ignored: done timing and result stay the same
    exp_q.push_back(24);
    wr(6, 0, 0);
    wr(6, 0, 0);
    chk("busy_start_busy", {30'd0, busy8, busy16}, 32'd3);
    poll_done(2, 6, 5, "busy_start");
    read_results(1, "busy_start");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
